// File: rtl/fb_arbiter_if.sv
// Display/host request bundle shared between fb_arbiter and its two clients.
interface fb_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 6
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_grant;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              host_valid;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              host_ready;
  logic              host_starve;

  modport master (
    output disp_req, disp_addr, host_valid, host_addr, host_data,
    input  disp_grant, disp_valid, disp_data, host_ready, host_starve
  );

  modport slave (
    input  disp_req, disp_addr, host_valid, host_addr, host_data,
    output disp_grant, disp_valid, disp_data, host_ready, host_starve
  );
endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: display reads win during active video, host writes win in blanking.
// Optional grant/accept statistics counters are enabled by defining FB_ARBITER_STATS_EN.
module fb_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 6,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blank,
  input  logic              frame_start,
  fb_arbiter_if.slave       bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARBITER_STATS_EN
  ,
  output logic [15:0]       disp_cnt,
  output logic [15:0]       host_cnt
`endif
);

  logic              disp_grant;
  logic              host_ready;
  logic              host_accept;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        rd_pipe_q;
  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;

  logic              wait_inc;
  logic [7:0]        wait_d, wait_q;
  logic              starve_set;
  logic              starve_d, starve_q;

  // Priority flips with blank; both grants are purely combinational so the switch costs no cycle.
  always_comb begin
    disp_grant = 1'b0;
    host_ready = 1'b0;
    if (blank) begin
      host_ready = bus.host_valid;
      disp_grant = bus.disp_req & ~bus.host_valid;
    end else begin
      disp_grant = bus.disp_req;
      host_ready = bus.host_valid & ~bus.disp_req;
    end
  end

  assign host_accept = bus.host_valid & host_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rd_pipe_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
    end else begin
      mem_en_q  <= disp_grant | host_accept;
      mem_we_q  <= host_accept;
      if (host_accept) begin
        mem_addr_q  <= bus.host_addr;
        mem_wdata_q <= bus.host_data;
      end else if (disp_grant) begin
        mem_addr_q  <= bus.disp_addr;
      end
      // Stage 0: address on RAM, stage 1: RAM data out, then registered to the display.
      rd_pipe_q    <= {rd_pipe_q[0], disp_grant};
      disp_valid_q <= rd_pipe_q[1];
      if (rd_pipe_q[1]) begin
        disp_data_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    wait_inc = bus.host_valid & ~host_ready;
    wait_d   = 8'd0;
    if (wait_inc) begin
      wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end
    // Set only on the cycle the count steps onto the limit, so frame_start can clear it.
    starve_set = wait_inc && (wait_q != 8'hFF) && ((32'(wait_q) + 32'd1) == STARVE_LIMIT);
    starve_d   = starve_set | (starve_q & ~frame_start);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q   <= 8'd0;
      starve_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

`ifdef FB_ARBITER_STATS_EN
  logic [15:0] disp_cnt_d, disp_cnt_q;
  logic [15:0] host_cnt_d, host_cnt_q;

  always_comb begin
    disp_cnt_d = disp_cnt_q;
    host_cnt_d = host_cnt_q;
    if (frame_start) begin
      disp_cnt_d = {15'd0, disp_grant};
      host_cnt_d = {15'd0, host_accept};
    end else begin
      if (disp_grant && disp_cnt_q != 16'hFFFF) disp_cnt_d = disp_cnt_q + 16'd1;
      if (host_accept && host_cnt_q != 16'hFFFF) host_cnt_d = host_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_cnt_q <= 16'd0;
      host_cnt_q <= 16'd0;
    end else begin
      disp_cnt_q <= disp_cnt_d;
      host_cnt_q <= host_cnt_d;
    end
  end

  assign disp_cnt = disp_cnt_q;
  assign host_cnt = host_cnt_q;
`endif

  assign bus.disp_grant  = disp_grant;
  assign bus.host_ready  = host_ready;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_data   = disp_data_q;
  assign bus.host_starve = starve_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed + randomized bench for fb_arbiter against a transaction-level memory/scoreboard model.
module tb_fb_arbiter;
  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 6;
  localparam int unsigned LIM = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          blank = 1'b0;
  logic          frame_start = 1'b0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef FB_ARBITER_STATS_EN
  logic [15:0]   disp_cnt, host_cnt;
`endif

  fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blank      (blank),
    .frame_start(frame_start),
    .bus        (bus),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef FB_ARBITER_STATS_EN
    ,
    .disp_cnt   (disp_cnt),
    .host_cnt   (host_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one-cycle read latency.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;
  logic [DW-1:0] mm [2**AW];
  rd_t           rdq[$];
  int            cyc = 0;
  logic          e_en = 0, e_we = 0, e_starve = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ddata = '0;
  int            wcnt = 0, e_dcnt = 0, e_hcnt = 0;
  int            grants = 0, pulses = 0;
  logic          last_wait = 0;
  int            checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_disp_valid", bus.disp_valid, 0);
    check("rst_disp_data", bus.disp_data, 0);
    check("rst_host_starve", bus.host_starve, 0);
  endtask

  // Called just after a posedge; inputs are already driven for this cycle.
  task automatic tick();
    logic g, r, acc, hv, fs, set;
    logic [AW-1:0] da, ha;
    logic [DW-1:0] hd;
    int prev;
    #3;
    g = blank ? (bus.disp_req & ~bus.host_valid) : bus.disp_req;
    r = blank ? bus.host_valid : (bus.host_valid & ~bus.disp_req);
    check("disp_grant", bus.disp_grant, g);
    check("host_ready", bus.host_ready, r);
    hv = bus.host_valid; acc = hv & r; fs = frame_start;
    da = bus.disp_addr; ha = bus.host_addr; hd = bus.host_data;
    @(posedge clk);
    #1;
    cyc++;
    last_wait = hv & ~r;
    if (acc) mm[ha] = hd;
    if (g) begin
      rdq.push_back('{cyc + 2, mm[da]});
      grants++;
    end
    e_en = g | acc;
    e_we = acc;
    if (acc) begin
      e_addr = ha; e_wdata = hd;
    end else if (g) begin
      e_addr = da;
    end
    set = 1'b0;
    if (hv && !r) begin
      prev = wcnt;
      wcnt = (wcnt < 255) ? wcnt + 1 : 255;
      set  = (wcnt == LIM) && (prev != LIM);
    end else begin
      wcnt = 0;
    end
    e_starve = set | (e_starve & ~fs);
    if (fs) begin
      e_dcnt = g ? 1 : 0; e_hcnt = acc ? 1 : 0;
    end else begin
      if (g && e_dcnt < 65535) e_dcnt++;
      if (acc && e_hcnt < 65535) e_hcnt++;
    end
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      e_ddata = rdq[0].data;
      void'(rdq.pop_front());
      check("disp_valid", bus.disp_valid, 1);
    end else begin
      check("disp_valid", bus.disp_valid, 0);
    end
    if (bus.disp_valid === 1'b1) pulses++;
    check("disp_data", bus.disp_data, e_ddata);
    check("host_starve", bus.host_starve, e_starve);
`ifdef FB_ARBITER_STATS_EN
    check("disp_cnt", disp_cnt, e_dcnt);
    check("host_cnt", host_cnt, e_hcnt);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    rdq.delete();
    e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_ddata = '0;
    wcnt = 0; e_starve = 0; e_dcnt = 0; e_hcnt = 0; last_wait = 0;
    @(posedge clk);
    #1;
    check_reset_outputs();
`ifdef FB_ARBITER_STATS_EN
    check("rst_disp_cnt", disp_cnt, 0);
    check("rst_host_cnt", host_cnt, 0);
`endif
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    bus.disp_req = 0; bus.host_valid = 0; frame_start = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int g0, p0;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = DW'(i * 7);
      mm[i]  = DW'(i * 7);
    end
    mem_rdata = '0;
    bus.disp_req = 0; bus.disp_addr = '0;
    bus.host_valid = 0; bus.host_addr = '0; bus.host_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // First grant right after release.
    blank = 0; bus.disp_req = 1; bus.disp_addr = AW'(15'h0123);
    tick();
    check("first_grant_en", mem_en, 1);
    idle(3);

    // Active video, both requesting for 10 cycles.
    g0 = grants; p0 = pulses;
    bus.host_valid = 1; bus.host_addr = AW'(15'h0042); bus.host_data = DW'(6'h15);
    for (int i = 0; i < 10; i++) begin
      bus.disp_req = 1; bus.disp_addr = AW'($urandom_range(0, 2**AW - 1));
      tick();
      check("s025_no_ready", bus.host_ready, 0);
    end
    idle(3);
    check("s025_grants", grants - g0, 10);
    check("s025_pulses", pulses - p0, 10);

    // Blanking: host wins, then read-after-write on the next cycle.
    blank = 1; bus.disp_req = 1; bus.disp_addr = AW'(15'h0055);
    bus.host_valid = 1; bus.host_addr = AW'(15'h0100); bus.host_data = DW'(6'h2A);
    tick();
    bus.host_valid = 0; bus.disp_addr = AW'(15'h0100);
    tick();
    bus.disp_req = 0;
    tick();
    tick();
    check("s026_valid", bus.disp_valid, 1);
    check("s026_data", bus.disp_data, 32'h2A);
    idle(2);

    // Starvation: sets after LIM waiting cycles, cleared by frame_start.
    blank = 0; bus.disp_req = 1; bus.host_valid = 1;
    bus.host_addr = AW'(15'h0777); bus.host_data = DW'(6'h09);
    for (int i = 0; i < LIM - 1; i++) tick();
    check("s027_pre", bus.host_starve, 0);
    tick();
    check("s027_set", bus.host_starve, 1);
    for (int i = 0; i < 10; i++) tick();
    check("s027_sticky", bus.host_starve, 1);
    frame_start = 1; tick(); frame_start = 0;
    check("s027_clear", bus.host_starve, 0);
    bus.host_valid = 0; tick();
    bus.host_valid = 1;
    for (int i = 0; i < LIM - 1; i++) tick();
    frame_start = 1; tick(); frame_start = 0;
    check("s027_set_wins", bus.host_starve, 1);
    bus.host_valid = 0; bus.disp_req = 0; frame_start = 1; tick(); frame_start = 0;
    check("s027_clear2", bus.host_starve, 0);
    idle(3);

    // Blank rises while both request: memory stays busy through the switch.
    blank = 0; bus.disp_req = 1; bus.disp_addr = AW'(15'h0200);
    bus.host_valid = 1; bus.host_addr = AW'(15'h0201); bus.host_data = DW'(6'h33);
    tick();
    blank = 1;
    tick();
    check("s029_en", mem_en, 1);
    check("s029_we", mem_we, 1);
    blank = 0;
    idle(4);

    // Reset one cycle after a display grant: the read must never surface.
    bus.disp_req = 1; bus.disp_addr = AW'(15'h0300);
    tick();
    bus.disp_req = 0;
    tick();
    do_reset();
    p0 = pulses;
    idle(5);
    check("s028_no_valid", pulses - p0, 0);

`ifdef FB_ARBITER_STATS_EN
    frame_start = 1; tick(); frame_start = 0;
    blank = 0;
    for (int i = 0; i < 5; i++) begin
      bus.disp_req = 1; bus.disp_addr = AW'(i); bus.host_valid = 0; tick();
    end
    for (int i = 0; i < 3; i++) begin
      bus.disp_req = 0; bus.host_valid = 1; bus.host_addr = AW'(15'h0400 + i);
      bus.host_data = DW'(i + 1); tick();
    end
    idle(1);
    check("s030_disp_cnt", disp_cnt, 5);
    check("s030_host_cnt", host_cnt, 3);
    frame_start = 1; tick(); frame_start = 0;
    check("s030_disp_clr", disp_cnt, 0);
    check("s030_host_clr", host_cnt, 0);
    idle(3);
`endif

    // Random traffic on a small address window to exercise read-after-write ordering.
    for (int i = 0; i < 400; i++) begin
      blank = ($urandom_range(0, 2) == 0);
      bus.disp_req = 1'($urandom_range(0, 1));
      bus.disp_addr = AW'(15'h0500 + $urandom_range(0, 7));
      if (!last_wait) begin
        bus.host_valid = 1'($urandom_range(0, 1));
        bus.host_addr = AW'(15'h0500 + $urandom_range(0, 7));
        bus.host_data = DW'($urandom);
      end
      frame_start = ($urandom_range(0, 31) == 0);
      tick();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 15, pixel RAM address width; DATA_W, default 6, pixel width (2b R, 2b G, 2b B); STARVE_LIMIT, default 64, host wait cycles before the starve flag sets.
REQ-002 SHALL have ports: clk  input  1  single clock, all logic on posedge; rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: blank  input  1  high outside the active video region; frame_start  input  1  one-cycle pulse at frame start.
REQ-004 SHALL have display ports: disp_req  in  1; disp_addr  in  ADDR_W; disp_grant  out  1; disp_valid  out  1; disp_data  out  DATA_W.
REQ-005 SHALL have host ports: host_valid  in  1; host_addr  in  ADDR_W; host_data  in  DATA_W; host_ready  out  1; host_starve  out  1 (sticky).
REQ-006 SHALL have memory ports: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (synchronous RAM, 1-cycle read latency).

Function
REQ-007 SHALL issue at most one memory operation per cycle.
REQ-008 When blank=0, disp_grant SHALL = disp_req and host_ready SHALL = host_valid & ~disp_req; both are combinational.
REQ-009 When blank=1, host_ready SHALL = host_valid and disp_grant SHALL = disp_req & ~host_valid.
REQ-010 A host write SHALL be accepted only on a cycle where host_valid & host_ready at posedge; host_addr and host_data SHALL be held stable while host_valid=1 & host_ready=0.
REQ-011 A grant in cycle N SHALL drive registered mem_en=1, mem_addr, mem_we and mem_wdata in cycle N+1.
REQ-012 For a display grant in cycle N, disp_valid SHALL pulse high in cycle N+3 and disp_data SHALL equal the registered mem_rdata; latency is fixed at 3 cycles with full throughput of 1 read per cycle.
REQ-013 With no grant, mem_en=0 and mem_we=0; mem_addr and mem_wdata SHALL hold their last values.
REQ-014 A wait counter (8b, saturating at 255) SHALL increment on each cycle with host_valid & ~host_ready, and SHALL clear on a host accept or when host_valid=0.
REQ-015 host_starve SHALL set when the wait counter reaches STARVE_LIMIT.
REQ-016 host_starve SHALL clear only on frame_start; if set and clear occur in the same cycle, set wins.
REQ-017 If blank changes in the same cycle as simultaneous requests, the arbitration SHALL use the blank value sampled in that cycle, with no cycle of dead time.
REQ-018 A write followed by a read of the same address in the next cycle SHALL return the new data, as ordering is preserved through the pipeline.

Reset
REQ-019 While rst_n=0, the following SHALL be 0 immediately, independent of clk: mem_en, mem_we, mem_addr, mem_wdata, disp_valid, disp_data, host_starve, the wait counter and the read pipeline.
REQ-020 Reads in flight when reset asserts SHALL be discarded, and no disp_valid SHALL be produced for them after release.
REQ-021 The first grant SHALL be possible on the first posedge after rst_n deasserts.

Configuration
REQ-022 When macro FB_ARBITER_STATS_EN is defined, the block SHALL add outputs disp_cnt[15:0] and host_cnt[15:0], counting display grants and host accepts.
REQ-023 disp_cnt and host_cnt SHALL saturate at 0xFFFF, SHALL clear on frame_start (a same-cycle event counts as 1), and SHALL reset to 0.
REQ-024 When FB_ARBITER_STATS_EN is undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-025 Scenario: blank=0, disp_req=1 and host_valid=1 for 10 cycles -> 10 disp_grant, host_ready=0 throughout, 10 disp_valid pulses 3 cycles after each grant.
REQ-026 Scenario: blank=1, both requesting -> host_ready=1 and disp_grant=0; host write 0x2A to addr 0x0100, then display reads 0x0100 -> disp_data=0x2A.
REQ-027 Scenario: blank=0, disp_req=1 continuously and host_valid=1, STARVE_LIMIT=64 -> host_starve rises after 64 waiting cycles, stays set, and clears on the frame_start pulse.
REQ-028 Scenario: rst_n pulled low 1 cycle after a display grant -> no disp_valid after release, all outputs 0 during reset.
REQ-029 Scenario: blank toggles 0->1 while both requesting -> the grant switches to host in the same cycle with no idle memory cycle.
REQ-030 Scenario: FB_ARBITER_STATS_EN defined, 5 grants and 3 accepts, then frame_start -> disp_cnt=5 and host_cnt=3 before the pulse, 0 after.
